// File: rtl/ripple_carry_sub_4bit_pkg.sv
// Shared width constant and operand type for the 4-bit ripple-borrow subtractor.
package ripple_carry_sub_4bit_pkg;

    localparam int WIDTH = 4;

    typedef logic [WIDTH-1:0] operand_t;

endpackage

// File: rtl/ripple_carry_sub_4bit_full_sub_1bit.sv
// One-bit full subtractor cell: difference and borrow-out from a - b - bin.
module full_sub_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ripple_carry_sub_4bit.sv
// 4-bit unsigned ripple-borrow subtractor with registered difference and borrow-out.
module ripple_carry_sub_4bit
    import ripple_carry_sub_4bit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  operand_t a,
    input  operand_t b,
    output operand_t sum,
    output logic     carry
);

    logic [WIDTH:0] borrowChain;
    operand_t       diff;
    operand_t       sum_d;
    operand_t       sum_q;
    logic           carry_d;
    logic           carry_q;

    // Borrow enters at the LSB as zero and ripples upward through each cell.
    assign borrowChain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
        full_sub_1bit u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (borrowChain[i]),
            .d    (diff[i]),
            .bout (borrowChain[i+1])
        );
    end

    always_comb begin
        sum_d   = diff;
        carry_d = borrowChain[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_ripple_carry_sub_4bit.sv
// Self-checking bench: expected {borrow, difference} pairs are queued as operands are applied.
module tb_ripple_carry_sub_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       carry;

    logic [4:0] expQ[$];
    int         checks = 0;
    int         errors = 0;

    ripple_carry_sub_4bit dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand pair, queues the reference result, and waits past the capturing edge.
    task automatic applyStimulus(input logic [3:0] aIn, input logic [3:0] bIn, input logic rIn);
        logic [4:0] ref5;
        a   = aIn;
        b   = bIn;
        rst = rIn;
        ref5 = rIn ? 5'h00 : ({1'b0, aIn} - {1'b0, bIn});
        expQ.push_back(ref5);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp5;
        applyStimulus(4'h7, 4'h2, 1'b1);
        exp5 = expQ.pop_front();
        checks++;
        if ({carry, sum} !== exp5 || exp5 !== 5'h00) begin
            errors++;
            $display("[TB] FAIL reset_edge1 got %b/%h want %b/%h", carry, sum, exp5[4], exp5[3:0]);
        end
        applyStimulus(4'h7, 4'h2, 1'b1);
        exp5 = expQ.pop_front();
        checks++;
        if ({carry, sum} !== exp5) begin
            errors++;
            $display("[TB] FAIL reset_edge2 got %b/%h want %b/%h", carry, sum, exp5[4], exp5[3:0]);
        end
        applyStimulus(4'h7, 4'h2, 1'b0);
        exp5 = expQ.pop_front();
        checks++;
        if ({carry, sum} !== 5'h05) begin
            errors++;
            $display("[TB] FAIL reset_release got %b/%h want 0/5", carry, sum);
        end
    endtask

    task automatic test_directed();
        logic [3:0] aList[6]  = '{4'h5, 4'h3, 4'h0, 4'h0, 4'hF, 4'hF};
        logic [3:0] bList[6]  = '{4'h3, 4'h5, 4'h1, 4'hF, 4'hF, 4'h0};
        logic [4:0] want[6]   = '{5'h02, 5'h1E, 5'h1F, 5'h11, 5'h00, 5'h0F};
        logic [4:0] exp5;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(aList[i], bList[i], 1'b0);
            exp5 = expQ.pop_front();
            checks++;
            if ({carry, sum} !== exp5 || exp5 !== want[i]) begin
                errors++;
                $display("[TB] FAIL directed a=%h b=%h got %b/%h want %b/%h",
                         aList[i], bList[i], carry, sum, want[i][4], want[i][3:0]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [4:0] exp5;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                applyStimulus(4'(ai), 4'(bi), (ai == 9 && bi == 12));
                exp5 = expQ.pop_front();
                checks++;
                if ({carry, sum} !== exp5) begin
                    errors++;
                    $display("[TB] FAIL sweep a=%h b=%h rst=%b got %b/%h want %b/%h",
                             4'(ai), 4'(bi), rst, carry, sum, exp5[4], exp5[3:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] aList[3] = '{4'h8, 4'h1, 4'h4};
        logic [3:0] bList[3] = '{4'h1, 4'h8, 4'h4};
        logic [4:0] want[3]  = '{5'h07, 5'h19, 5'h00};
        logic [4:0] exp5;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(aList[i], bList[i], 1'b0);
            exp5 = expQ.pop_front();
            checks++;
            if ({carry, sum} !== exp5 || exp5 !== want[i]) begin
                errors++;
                $display("[TB] FAIL back_to_back step=%0d got %b/%h want %b/%h",
                         i, carry, sum, want[i][4], want[i][3:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'h0;
        b   = 4'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d left want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ripple_carry_sub_4bit.md
Name: ripple_carry_sub_4bit

Overview:
- 4-bit unsigned ripple-borrow subtractor computing a - b. Output is registered.
- Built from a chain of four 1-bit full-subtractor cells. Borrow ripples from bit 0 to bit 3.
- Used as a small arithmetic leaf in the arithmetic/logic datapath. It sits after operand selection, and the difference and borrow go to downstream logic.

Parameters:
- none. Width is fixed at 4 bits.

Ports:
- clk    input   1  rising-edge clock
- rst    input   1  synchronous, active-high reset
- a      input   4  minuend, unsigned
- b      input   4  subtrahend, unsigned
- sum    output  4  registered difference, (a - b) mod 16
- carry  output  1  registered borrow-out: 1 when a < b (unsigned), else 0

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset:
  - On a rising clk edge with rst=1: sum <= 4'h0 and carry <= 1'b0.
  - rst overrides the new operands on that same edge.
- Combinational core:
  - Bit i computes d_i = a_i ^ b_i ^ bin_i.
  - Borrow out: bout_i = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i).
  - bin_0 = 0 and bin_(i+1) = bout_i. The final borrow is bout_3.
- Latency:
  - When rst=0, each rising edge registers sum <= d[3:0] and carry <= bout_3, using the a/b values present before that edge.
  - Result is visible exactly 1 cycle after the operands are applied.
  - Throughput is one new operand pair per cycle. There is no handshake and no stall.
- Arithmetic rules:
  - Result width is 4 bits. Wrap-around is modulo 16.
  - The {carry, sum} pair equals the 5-bit two's-complement value of a - b. Bit 4 is set iff a < b.
- Boundary conditions:
  - a == b: sum=0, carry=0.
  - a=0 with any b>0: carry=1 and sum=16-b.
  - a=F, b=0: sum=F, carry=0.
  - a=0, b=F: sum=1, carry=1.
- Reset mid-stream: the output in the cycle after the rst edge is 0/0. The first valid result appears one cycle after rst is deasserted, computed from the operands present at that edge.
- X handling: sum and carry never show X after the first reset edge, provided the inputs are known.
- No internal state exists beyond the two output registers.

Decomposition:
- Shared package: a WIDTH constant = 4 and an operand typedef logic [3:0]. No other typedefs are needed.
- Sub-module full_sub_1bit with ports a, b, bin (inputs) and d, bout (outputs). It is instantiated 4 times in a generate loop, chained through bin/bout.
- The top level contains only the chain and the output register with synchronous reset.

Test Plan:
- Reset: hold rst=1 with a=7, b=2 for 2 edges -> sum=0, carry=0. Deassert rst -> one edge later sum=5, carry=0.
- Basic results, each checked one cycle after apply:
  - a=5, b=3 -> sum=2, carry=0.
  - a=3, b=5 -> sum=E, carry=1.
- Wrap and extremes:
  - a=0, b=1 -> sum=F, carry=1.
  - a=0, b=F -> sum=1, carry=1.
  - a=F, b=F -> sum=0, carry=0.
  - a=F, b=0 -> sum=F, carry=0.
- Exhaustive: sweep a=0..F (outer loop) and b=0..F (inner loop), one pair per cycle. Each output must equal {carry, sum} == (a - b) & 5'h1F, computed against a pipeline-delayed reference.
- Reset mid-stream: during the sweep, assert rst for one edge at a=9, b=C -> next cycle sum=0, carry=0. Deassert -> the next result resumes the correct value for the operands then present.
- Back-to-back: change operands every cycle, e.g. (8,1) then (1,8) then (4,4) -> outputs (7,0), (9,1), (0,0) on consecutive cycles.
